mux_scan_seq: RTL
=================

MUX_SCAN_SEQ -- requirements
Module: mux_scan_seq

Interface
REQ-001 Parameter BIT_HOLD, default 1: number of clk cycles each select index is held before mux_y is sampled; legal range 1..16.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset; synchronous, active-low.
REQ-004 load_valid  in  1  upstream offers a byte on load_data.
REQ-005 load_data  in  8  byte to serialize through the 8:1 mux.
REQ-006 load_ready  out  1  block can accept a byte this cycle.
REQ-007 mux_g  out  1  active-low strobe to the mux (0 = mux enabled).
REQ-008 mux_a, mux_b, mux_c  out  1 each  mux select; a = index bit 0, b = bit 1, c = bit 2.
REQ-009 mux_d  out  8  data word driven to mux data inputs.
REQ-010 mux_y  in  1  mux true output, sampled by this block.
REQ-011 ser_bit  out  1  serialized bit, valid when ser_valid = 1.
REQ-012 ser_valid  out  1  one-cycle qualifier per serialized bit.
REQ-013 frame_done  out  1  one-cycle pulse at frame end.
REQ-014 rx_data  out  8  byte reassembled from the 8 samples; bit i = sample at index i.
REQ-015 err  out  1  set at frame end if rx_data != latched word.

Function
REQ-016 All outputs shall be registered; the FSM states shall be IDLE, SETUP, SCAN, DONE.
REQ-017 IDLE: load_ready = 1, mux_g = 1, select = 0; on load_valid && load_ready at edge T, latch load_data into mux_d, drop load_ready, go to SETUP.
REQ-018 SETUP (cycle T+1): mux_g = 1, select = 0 (settling cycle); next state SCAN.
REQ-019 SCAN: mux_g = 0; index runs 0..7 in ascending order, each index held for exactly BIT_HOLD cycles.
REQ-020 mux_y shall be sampled on the last hold cycle of each index; ser_bit/ser_valid shall present that sample on the following cycle.
REQ-021 Sample i shall be written to rx_data[i]; rx_data bits not yet sampled in a frame shall hold their previous value.
REQ-022 After the last hold cycle of index 7, the FSM shall enter DONE at cycle T+2+8*BIT_HOLD with mux_g = 1, frame_done = 1, and err = (rx_data != mux_d).
REQ-023 DONE shall last one cycle; the FSM then returns to IDLE; load_ready = 1 from cycle T+3+8*BIT_HOLD.
REQ-024 The ser_valid for index 7 shall coincide with frame_done.
REQ-025 load_valid while load_ready = 0 shall be ignored; load_data shall not be captured.
REQ-026 mux_d shall stay constant from capture until the next accepted load.
REQ-027 The index counter shall not wrap within a frame; index 7 shall terminate the scan.
REQ-028 The hold counter shall be sized for 16 and shall clear at each index change.
REQ-029 err shall hold its value until the next DONE or reset; frame_done and ser_valid shall never be high for more than one consecutive cycle, except on back-to-back bits when BIT_HOLD = 1.

Reset
REQ-030 rst_n = 0 at an edge shall force IDLE with load_ready = 1, mux_g = 1, mux_a/b/c = 0, mux_d = 0, ser_bit = 0, ser_valid = 0, frame_done = 0, rx_data = 0, err = 0.
REQ-031 Reset during SETUP or SCAN shall abandon the frame with no frame_done and no further ser_valid; a load_valid in the first cycle after release shall be accepted normally.

Verification
REQ-032 BIT_HOLD=1, load 8'hA5 at T -> ser_valid T+3..T+10, ser_bit 1,0,1,0,0,1,0,1; frame_done at T+10; rx_data = 8'hA5; err = 0; load_ready = 1 at T+11.
REQ-033 BIT_HOLD=3, load 8'h01 -> each select held for 3 cycles; ser_valid at T+5, T+8, ..., T+26; frame_done at T+26.
REQ-034 load_valid held high with 8'hFF during a frame -> ignored; the next byte is accepted only at T+11 (BIT_HOLD=1).
REQ-035 Force mux_y stuck at 0, load 8'h80 -> rx_data = 8'h00; err = 1 with frame_done.
REQ-036 rst_n low at SCAN index 4 -> next cycle all REQ-030 values; no frame_done; a new load of 8'h3C completes with rx_data = 8'h3C.
REQ-037 Select sequence check: on each SCAN cycle, {mux_c, mux_b, mux_a} = index, with mux_g = 0 only in SCAN.

Source files
------------

// File: rtl/mux_scan_seq.sv
// Serializes a byte through an external 8:1 mux by stepping its select lines,
// samples the mux output per index, and reassembles the samples into rx_data.
module mux_scan_seq #(
  parameter int unsigned BIT_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  output logic       mux_g,
  output logic       mux_a,
  output logic       mux_b,
  output logic       mux_c,
  output logic [7:0] mux_d,
  input  logic       mux_y,
  output logic       ser_bit,
  output logic       ser_valid,
  output logic       frame_done,
  output logic [7:0] rx_data,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Hold counter is 5 bits so the full 1..16 hold range fits.
  localparam logic [4:0] HOLD_LAST = 5'(BIT_HOLD - 1);

  state_t      state_q;
  logic [2:0]  idx_q;
  logic [4:0]  hold_q;
  logic        load_ready_q;
  logic        mux_g_q;
  logic [7:0]  mux_d_q;
  logic        ser_bit_q;
  logic        ser_valid_q;
  logic        frame_done_q;
  logic [7:0]  rx_q;
  logic [7:0]  rx_d;
  logic        err_q;

  // rx_d includes the sample being taken now so err sees all eight bits.
  always_comb begin
    rx_d        = rx_q;
    rx_d[idx_q] = mux_y;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      hold_q       <= '0;
      load_ready_q <= 1'b1;
      mux_g_q      <= 1'b1;
      mux_d_q      <= '0;
      ser_bit_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      rx_q         <= '0;
      err_q        <= 1'b0;
    end else begin
      ser_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_valid && load_ready_q) begin
            mux_d_q      <= load_data;
            load_ready_q <= 1'b0;
            state_q      <= SETUP;
          end
        end
        SETUP: begin
          mux_g_q <= 1'b0;
          idx_q   <= '0;
          hold_q  <= '0;
          state_q <= SCAN;
        end
        SCAN: begin
          if (hold_q == HOLD_LAST) begin
            ser_bit_q   <= mux_y;
            ser_valid_q <= 1'b1;
            rx_q        <= rx_d;
            hold_q      <= '0;
            if (idx_q == 3'd7) begin
              idx_q        <= '0;
              mux_g_q      <= 1'b1;
              frame_done_q <= 1'b1;
              err_q        <= (rx_d != mux_d_q);
              state_q      <= DONE;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            hold_q <= hold_q + 5'd1;
          end
        end
        DONE: begin
          load_ready_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_ready = load_ready_q;
  assign mux_g      = mux_g_q;
  assign mux_a      = idx_q[0];
  assign mux_b      = idx_q[1];
  assign mux_c      = idx_q[2];
  assign mux_d      = mux_d_q;
  assign ser_bit    = ser_bit_q;
  assign ser_valid  = ser_valid_q;
  assign frame_done = frame_done_q;
  assign rx_data    = rx_q;
  assign err        = err_q;

endmodule
